// File: rtl/xunit_m.sv
// SHA-256 message-schedule generator: streams W[0..63] for each 16-word block.
// Optional multi-block chaining under `XUNITM_MULTIBLOCK_EN.
module xunit_m #(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  input  logic [DELAY_W-1:0] delay0
`ifdef XUNITM_MULTIBLOCK_EN
  ,
  input  logic [7:0]         nblocks0
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    WORK = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [5:0]         t;
  logic [DELAY_W-1:0] delay;
  logic [DATA_W-1:0]  win [16];
  logic [DATA_W-1:0]  w_t;
  logic               round_en;
  logic               more_blocks;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef XUNITM_MULTIBLOCK_EN
  logic [7:0] blocks_left;

  assign more_blocks = (blocks_left > 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      blocks_left <= 8'd0;
    end else if (run) begin
      blocks_left <= (nblocks0 == 8'd0) ? 8'd1 : nblocks0;
    end else if (round_en && t == 6'd63 && more_blocks) begin
      blocks_left <= blocks_left - 8'd1;
    end
  end
`else
  assign more_blocks = 1'b0;
`endif

  // Round 0 of the first block happens in WAIT, on the cycle the delay expires.
  assign round_en = ((state == WAIT) && (delay == '0)) || (state == WORK);
  assign w_t      = (t < 6'd16) ? in0
                  : sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign done     = (state == IDLE);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: state_d = IDLE;
      WAIT: if (delay == '0) state_d = WORK;
      WORK: if (t == 6'd63) state_d = more_blocks ? WORK : IDLE;
      default: state_d = IDLE;
    endcase
    if (run) state_d = WAIT;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: the window is cleared on reset because its contents are part of the defined reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      t     <= 6'd0;
      delay <= '0;
      out0  <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (run) begin
      delay <= delay0;
      t     <= 6'd0;
    end else begin
      if (state == WAIT && delay != '0) delay <= delay - DELAY_W'(1);
      if (round_en) begin
        out0 <= w_t;
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_t;
        t       <= t + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_xunit_m.sv
// Self-checking bench for xunit_m: scoreboard of SHA-256 schedule words.
// Multi-block test is built when XUNITM_MULTIBLOCK_EN is defined.
module tb_xunit_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [31:0] delay0;
`ifdef XUNITM_MULTIBLOCK_EN
  logic [7:0]  nblocks0;
`endif

  xunit_m #(.DELAY_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .done(done),
    .in0(in0),
    .out0(out0),
    .delay0(delay0)
`ifdef XUNITM_MULTIBLOCK_EN
    ,
    .nblocks0(nblocks0)
`endif
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] msg [16];
  logic [31:0] exp_q [$];
  logic [31:0] obs [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference schedule from the current msg[] pushed onto the scoreboard.
  task automatic push_block();
    logic [31:0] w [64];
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) w[i] = msg[i];
    for (int i = 16; i < 64; i++) begin
      a = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      b = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = b + w[i-7] + a + w[i-16];
    end
    for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
  endtask

  task automatic start_run(input int unsigned d);
    run    = 1'b1;
    delay0 = d;
    in0    = $urandom;
    @(negedge clk);
    run = 1'b0;
    check("done_after_run", {31'd0, done}, 32'd0);
    for (int k = 0; k < int'(d); k++) begin
      in0 = $urandom;
      @(negedge clk);
      check("done_wait", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic feed(input int n, input int total);
    int r64;
    for (int r = 0; r < n; r++) begin
      r64 = r % 64;
      in0 = (r64 < 16) ? msg[r64] : $urandom;
      @(negedge clk);
      obs[r] = out0;
      if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
      else check($sformatf("w%0d", r), out0, exp_q.pop_front());
      check($sformatf("done_r%0d", r), {31'd0, done}, {31'd0, (r == total - 1)});
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  logic [31:0] held;

  initial begin
    rst    = 1'b1;
    run    = 1'b0;
    in0    = 32'h0;
    delay0 = 32'h0;
`ifdef XUNITM_MULTIBLOCK_EN
    nblocks0 = 8'd1;
`endif
    // Reset for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("rst_out0", out0, 32'h0);
    check("rst_done", {31'd0, done}, 32'd1);

    // run together with rst must be ignored.
    run = 1'b1;
    @(negedge clk);
    check("rst_run_done", {31'd0, done}, 32'd1);
    run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_run_idle", {31'd0, done}, 32'd1);
    check("rst_run_out0", out0, 32'h0);

    // "abc" block, no delay.
    load_abc();
    push_block();
    start_run(0);
    feed(64, 64);
    check("abc_w0", obs[0], 32'h61626380);
    check("abc_w15", obs[15], 32'h00000018);
    check("abc_w16", obs[16], 32'h61626380);
    check("abc_w17", obs[17], 32'h000F0000);
    held = obs[63];
    for (int k = 0; k < 3; k++) begin
      in0 = $urandom;
      @(negedge clk);
      check("idle_hold_out0", out0, held);
      check("idle_done", {31'd0, done}, 32'd1);
    end

    // Start delay of 3.
    load_random();
    push_block();
    start_run(3);
    feed(64, 64);

    // Abort at round 30 and restart.
    load_random();
    push_block();
    start_run(0);
    feed(30, 64);
    held = out0;
    exp_q.delete();
    load_random();
    push_block();
    start_run(0);
    check("abort_out0_hold", out0, held);
    feed(64, 64);
    check("abort_new_w0", obs[0], msg[0]);

`ifdef XUNITM_MULTIBLOCK_EN
    // Two chained "abc" blocks.
    nblocks0 = 8'd2;
    load_abc();
    push_block();
    push_block();
    start_run(0);
    feed(128, 128);
    for (int i = 0; i < 64; i++) check($sformatf("mb_half%0d", i), obs[i+64], obs[i]);
    nblocks0 = 8'd1;
`endif

    // Random blocks with random short delays.
    for (int b = 0; b < 50; b++) begin
      load_random();
      push_block();
      start_run($urandom_range(0, 2));
      feed(64, 64);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
